// File: rtl/wf_setpoint_sequencer.sv
// Waveform setpoint sequencer: walks a BRAM sample table once per DSP frame flag and loops it a programmed number of times.
// Build option: define WF_UNDERRUN_DET_EN to build the sticky underrun detector; otherwise o_wf_underrun is tied low.
module wf_setpoint_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_wf_en,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W:0]   i_wf_len,
  input  logic [15:0]       i_wf_loop,
  input  logic              i_wf_set_flag,
  output logic              o_wf_bram_en,
  output logic [ADDR_W-1:0] o_wf_bram_addr,
  input  logic [31:0]       i_wf_bram_dout,
  output logic [31:0]       o_wf_sp,
  output logic              o_wf_busy,
  output logic              o_wf_done,
  output logic [ADDR_W-1:0] o_wf_idx,
  output logic [15:0]       o_wf_pass,
  output logic              o_wf_underrun
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W-1:0] rd_addr_nxt_s;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   len_m1_s;
  logic [15:0]       loop_r;
  logic [15:0]       pass_r;
  logic [15:0]       pass_inc_s;
  logic [1:0]        en_r;
  logic [31:0]       next_r;
  logic [31:0]       sp_r;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] bram_addr_r;
  logic              bram_en_r;
  logic              busy_r;
  logic              done_r;
  logic              en_ok_s;
  logic              start_ok_s;
  logic              busy_state_s;
  logic              abort_s;
  logic              last_s;
  logic              finish_s;
  logic              flag_take_s;

  // Control decode: start qualification, abort, end-of-table and end-of-run detection
  always_comb begin
    en_ok_s      = (i_wf_en == 2'd1) || (i_wf_en == 2'd3);
    start_ok_s   = (state_r == ST_IDLE) && i_start && !i_stop && en_ok_s &&
                   (i_wf_len != {(ADDR_W+1){1'b0}});
    busy_state_s = (state_r == ST_FETCH) || (state_r == ST_LOAD) || (state_r == ST_WAIT);
    // en_r is non-zero for the whole run, so a target change to off/reserved aborts it
    abort_s      = busy_state_s && (i_stop || (!en_ok_s && (en_r != 2'd0)));
    len_m1_s     = len_r - {{ADDR_W{1'b0}}, 1'b1};
    last_s       = ({1'b0, rd_addr_r} == len_m1_s);
    pass_inc_s   = (pass_r == 16'hFFFF) ? pass_r : (pass_r + 16'd1);
    flag_take_s  = (state_r == ST_WAIT) && i_wf_set_flag && !abort_s;
    finish_s     = last_s && (loop_r != 16'd0) && (pass_inc_s == loop_r);
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else if (flag_take_s) begin
          state_nxt_s = finish_s ? ST_DONE : ST_FETCH;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next table address: restarts on start, advances modulo len on each presented sample
  always_comb begin
    rd_addr_nxt_s = rd_addr_r;
    if (start_ok_s) begin
      rd_addr_nxt_s = {ADDR_W{1'b0}};
    end else if (flag_take_s) begin
      rd_addr_nxt_s = last_s ? {ADDR_W{1'b0}} : (rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1});
    end else begin
      rd_addr_nxt_s = rd_addr_r;
    end
  end

  // State, address and registered status strobes (aligned with the state they describe)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      rd_addr_r   <= {ADDR_W{1'b0}};
      bram_en_r   <= 1'b0;
      bram_addr_r <= {ADDR_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rd_addr_r <= rd_addr_nxt_s;
      bram_en_r <= (state_nxt_s == ST_FETCH);
      busy_r    <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_LOAD) ||
                   (state_nxt_s == ST_WAIT);
      done_r    <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_FETCH) begin
        bram_addr_r <= rd_addr_nxt_s;
      end
    end
  end

  // Run configuration latched on an accepted start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_r  <= {(ADDR_W+1){1'b0}};
      loop_r <= 16'd0;
      en_r   <= 2'd0;
    end else if (start_ok_s) begin
      len_r  <= i_wf_len;
      loop_r <= i_wf_loop;
      en_r   <= i_wf_en;
    end
  end

  // Sample datapath: prefetch register, presented setpoint, index and pass count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      next_r <= 32'd0;
      sp_r   <= 32'd0;
      idx_r  <= {ADDR_W{1'b0}};
      pass_r <= 16'd0;
    end else begin
      if ((state_r == ST_LOAD) && !abort_s) begin
        next_r <= i_wf_bram_dout;
      end
      if (start_ok_s) begin
        pass_r <= 16'd0;
      end else if (flag_take_s) begin
        sp_r  <= next_r;
        idx_r <= rd_addr_r;
        if (last_s) begin
          pass_r <= pass_inc_s;
        end
      end
    end
  end

`ifdef WF_UNDERRUN_DET_EN
  logic underrun_r;
  logic underrun_evt_s;

  // A frame flag arriving before the prefetch has landed
  always_comb begin
    underrun_evt_s = i_wf_set_flag && !abort_s &&
                     ((state_r == ST_FETCH) || (state_r == ST_LOAD));
  end

  // Sticky underrun flag, cleared only by an accepted start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      underrun_r <= 1'b0;
    end else if (start_ok_s) begin
      underrun_r <= 1'b0;
    end else if (underrun_evt_s) begin
      underrun_r <= 1'b1;
    end
  end

  assign o_wf_underrun = underrun_r;
`else
  assign o_wf_underrun = 1'b0;
`endif

  assign o_wf_bram_en   = bram_en_r;
  assign o_wf_bram_addr = bram_addr_r;
  assign o_wf_sp        = sp_r;
  assign o_wf_busy      = busy_r;
  assign o_wf_done      = done_r;
  assign o_wf_idx       = idx_r;
  assign o_wf_pass      = pass_r;

endmodule
